// File: rtl/mux_scan_serializer.sv
// Serializer front end for the 16:1 mux: holds a word on the mux data
// inputs, walks the select once per clock and registers the mux output.
module mux_scan_serializer #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_data,
   input  logic        hold,
   output logic [3:0]  mux_sel,
   output logic [15:0] mux_di,
   input  logic        mux_y,
   output logic        sout,
   output logic        sout_valid,
   output logic        sout_last,
   output logic        busy
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [3:0] SEL_START = MSB_FIRST ? 4'hF : 4'h0;
   localparam logic [3:0] SEL_END   = MSB_FIRST ? 4'h0 : 4'hF;

   state_t      state;
   state_t      state_nx;
   logic [3:0]  sel_nx;
   logic [3:0]  sel_step;
   logic [15:0] di_nx;
   logic        sout_nx;
   logic        valid_nx;
   logic        last_nx;
   logic        busy_nx;
   logic        at_end;

   assign load_ready = (state == IDLE);
   assign at_end     = (mux_sel == SEL_END);
   assign sel_step   = MSB_FIRST ? (mux_sel - 4'd1)
                                 : (mux_sel + 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mux_sel    <= SEL_START;
         mux_di     <= 16'h0000;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sout_last  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         mux_sel    <= sel_nx;
         mux_di     <= di_nx;
         sout       <= sout_nx;
         sout_valid <= valid_nx;
         sout_last  <= last_nx;
         busy       <= busy_nx;
      end
   end

   always_comb begin
      state_nx = state;
      sel_nx   = mux_sel;
      di_nx    = mux_di;
      sout_nx  = sout;
      valid_nx = 1'b0;
      last_nx  = 1'b0;
      busy_nx  = busy;
      unique case (1'b1)
         (state == IDLE): begin
            if (load_valid) begin
               di_nx    = load_data;
               sel_nx   = SEL_START;
               state_nx = SCAN;
               busy_nx  = 1'b1;
            end
         end
         (state == SCAN && hold): begin
         end
         (state == SCAN && !hold): begin
            sout_nx  = mux_y;
            valid_nx = 1'b1;
            if (at_end) begin
               // last bit: release the word, mux_di stays put
               last_nx  = 1'b1;
               state_nx = IDLE;
               busy_nx  = 1'b0;
               sel_nx   = SEL_START;
            end else begin
               sel_nx = sel_step;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench: two serializers (LSB-first and MSB-first), each
// closed through a behavioral 16:1 mux.
module tb_mux_scan_serializer;

   logic        clk;
   logic        rst_n;
   logic        lv0, lv1;
   logic        rdy0, rdy1;
   logic [15:0] ld0, ld1;
   logic        hold0, hold1;
   logic [3:0]  sel0, sel1;
   logic [15:0] di0, di1;
   logic        y0, y1;
   logic        so0, so1;
   logic        sv0, sv1;
   logic        sl0, sl1;
   logic        busy0, busy1;

   int n_chk;
   int n_err;

   assign y0 = di0[sel0];
   assign y1 = di1[sel1];

   mux_scan_serializer #(.MSB_FIRST(1'b0)) u_lsb (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (lv0),
      .load_ready (rdy0),
      .load_data  (ld0),
      .hold       (hold0),
      .mux_sel    (sel0),
      .mux_di     (di0),
      .mux_y      (y0),
      .sout       (so0),
      .sout_valid (sv0),
      .sout_last  (sl0),
      .busy       (busy0)
   );

   mux_scan_serializer #(.MSB_FIRST(1'b1)) u_msb (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (lv1),
      .load_ready (rdy1),
      .load_data  (ld1),
      .hold       (hold1),
      .mux_sel    (sel1),
      .mux_di     (di1),
      .mux_y      (y1),
      .sout       (so1),
      .sout_valid (sv1),
      .sout_last  (sl1),
      .busy       (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] get_sel(input bit msb);
      return msb ? sel1 : sel0;
   endfunction

   function automatic logic get_sv(input bit msb);
      return msb ? sv1 : sv0;
   endfunction

   function automatic logic get_sl(input bit msb);
      return msb ? sl1 : sl0;
   endfunction

   function automatic logic get_so(input bit msb);
      return msb ? so1 : so0;
   endfunction

   function automatic logic get_rdy(input bit msb);
      return msb ? rdy1 : rdy0;
   endfunction

   function automatic logic get_busy(input bit msb);
      return msb ? busy1 : busy0;
   endfunction

   task automatic set_hold(input bit msb, input logic v);
      if (msb) hold1 = v;
      else     hold0 = v;
   endtask

   task automatic set_load(input bit msb, input logic v,
                           input logic [15:0] d);
      if (msb) begin
         lv1 = v;
         ld1 = d;
      end else begin
         lv0 = v;
         ld0 = d;
      end
   endtask

   // Starts at the negedge after the accept edge. exp_s[k] is the
   // k-th serial bit expected on sout.
   task automatic collect(input bit msb,
                          input logic [15:0] exp_s,
                          input int hold_after,
                          input int hold_len,
                          input int stop_bits,
                          input string tag);
      int nb, cyc, gaps, hcnt, sel_err, last_cnt, idx;
      logic [15:0] got;
      logic [3:0]  start;
      nb = 0; cyc = 0; gaps = 0; hcnt = 0;
      sel_err = 0; last_cnt = 0; got = '0;
      start = msb ? 4'hF : 4'h0;
      while (nb < stop_bits && cyc < 40) begin
         idx = msb ? 15 - nb : nb;
         if (get_sel(msb) != idx[3:0]) sel_err++;
         if (nb == hold_after && hcnt < hold_len) begin
            set_hold(msb, 1'b1);
            hcnt++;
         end else begin
            set_hold(msb, 1'b0);
         end
         @(negedge clk);
         cyc++;
         if (get_sv(msb)) begin
            got[nb] = get_so(msb);
            if (get_sl(msb)) last_cnt += (nb == 15) ? 1 : 100;
            nb++;
         end else begin
            gaps++;
            if (get_sl(msb)) last_cnt += 100;
         end
      end
      set_hold(msb, 1'b0);
      chk({tag, "_bits"}, 32'(got), 32'(exp_s));
      chk({tag, "_sel_seq"}, 32'(sel_err), 32'd0);
      if (stop_bits == 16) begin
         chk({tag, "_cycles"}, 32'(cyc), 32'(16 + hold_len));
         chk({tag, "_gaps"}, 32'(gaps), 32'(hold_len));
         chk({tag, "_last"}, 32'(last_cnt), 32'd1);
         chk({tag, "_rdy_end"}, 32'(get_rdy(msb)), 32'd1);
         chk({tag, "_busy_end"}, 32'(get_busy(msb)), 32'd0);
         chk({tag, "_sel_end"}, 32'(get_sel(msb)), 32'(start));
      end else begin
         chk({tag, "_no_last"}, 32'(last_cnt), 32'd0);
      end
   endtask

   task automatic run_word(input bit msb,
                           input logic [15:0] w,
                           input logic [15:0] exp_s,
                           input int hold_after,
                           input int hold_len,
                           input string tag);
      set_load(msb, 1'b1, w);
      @(negedge clk);
      chk({tag, "_busy"}, 32'(get_busy(msb)), 32'd1);
      chk({tag, "_rdy"}, 32'(get_rdy(msb)), 32'd0);
      set_load(msb, 1'b0, 16'h0000);
      collect(msb, exp_s, hold_after, hold_len, 16, tag);
   endtask

   initial begin
      int vcnt;
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      lv0 = 1'b0; lv1 = 1'b0;
      ld0 = '0; ld1 = '0;
      hold0 = 1'b0; hold1 = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_sel0", 32'(sel0), 32'h0);
      chk("rst_sel1", 32'(sel1), 32'hF);
      chk("rst_di0", 32'(di0), 32'h0);
      chk("rst_outs",
          32'({so0, sv0, sl0, busy0, so1, sv1, sl1, busy1}),
          32'h0);
      rst_n = 1'b1;
      vcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (sv0 || sv1 || sl0 || sl1) vcnt++;
      end
      chk("idle_rdy", 32'({rdy0, rdy1}), 32'h3);
      chk("idle_busy", 32'({busy0, busy1}), 32'h0);
      chk("idle_no_valid", 32'(vcnt), 32'd0);

      run_word(1'b0, 16'hA5C3, 16'hA5C3, 99, 0, "lsb_a5c3");
      run_word(1'b1, 16'h8001, 16'h8001, 99, 0, "msb_8001");
      run_word(1'b1, 16'h00F1, 16'h8F00, 99, 0, "msb_00f1");
      run_word(1'b0, 16'hFFFF, 16'hFFFF, 5, 3, "hold_ffff");

      // load_valid stays high across the whole first word
      set_load(1'b0, 1'b1, 16'h0001);
      @(negedge clk);
      chk("b2b_busy1", 32'(busy0), 32'd1);
      collect(1'b0, 16'h0001, 99, 0, 16, "b2b_w1");
      chk("b2b_di_kept", 32'(di0), 32'h0001);
      ld0 = 16'h0002;
      @(negedge clk);
      chk("b2b_e17_busy", 32'(busy0), 32'd1);
      chk("b2b_e17_di", 32'(di0), 32'h0002);
      lv0 = 1'b0;
      collect(1'b0, 16'h0002, 99, 0, 16, "b2b_w2");

      set_load(1'b0, 1'b1, 16'h1234);
      @(negedge clk);
      set_load(1'b0, 1'b0, 16'h0000);
      collect(1'b0, 16'h0034, 99, 0, 8, "rst_mid");
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_state",
          32'({sel0, so0, sv0, sl0, busy0}), 32'h0);
      chk("rst_mid_di", 32'(di0), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_rdy", 32'(rdy0), 32'd1);
      run_word(1'b0, 16'h0F0F, 16'h0F0F, 99, 0, "post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
